inst_mem_loader: RTL and testbench

//  Write-side companion to the instruction memory: streams 16-bit instruction words

---
 rtl/inst_mem_loader_if.sv | 34 +++
 rtl/inst_mem_loader.sv | 149 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// Loader-side bus bundle for inst_mem_loader.
//   start/base_addr/word_count : load request, sampled only when the loader is idle
//   in_data/in_valid/in_ready  : instruction word stream from the boot ROM / debug source
//   mem_we/mem_addr/mem_wdata  : byte write port into the instruction store
//   busy/cpu_hold/done/exc     : status back to the system
// The "slave" modport is the loader itself; "master" is the request/source side.
interface inst_mem_loader_if #(
  parameter int unsigned INST_ADDR_WIDTH = 16,
  parameter int unsigned INST_DATA_WIDTH = 16
);
  logic                       start;
  logic [INST_ADDR_WIDTH-1:0] base_addr;
  logic [15:0]                word_count;
  logic [INST_DATA_WIDTH-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       mem_we;
  logic [INST_ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]                 mem_wdata;
  logic                       busy;
  logic                       cpu_hold;
  logic                       done;
  logic                       exc;

  modport slave (
    input  start, base_addr, word_count, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, exc
  );

  modport master (
    output start, base_addr, word_count, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, exc
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: streams 16-bit instruction words from a loader source into
// the byte-addressed instruction store as two little-endian byte writes (low byte at
// addr, high byte at addr+1), holding the CPU off while a load is in progress.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous reset, active-low
//   bus  : inst_mem_loader_if.slave (request, word stream, byte write port, status)
// Every output is decoded from registered state only.
module inst_mem_loader #(
  parameter int unsigned INST_ADDR_WIDTH = 16,
  parameter int unsigned INST_DATA_WIDTH = 16,
  parameter int unsigned INST_MEM_SIZE   = 4096
) (
  input logic              clk,
  input logic              rst,
  inst_mem_loader_if.slave bus
);

  localparam int unsigned CountWidth  = 16;
  localparam int unsigned LastWordInt = INST_MEM_SIZE - 2;
  // One extra bit so a pointer that has run past the top of a 64 KiB map still compares high.
  localparam logic [INST_ADDR_WIDTH:0] LastWordAddr = LastWordInt[INST_ADDR_WIDTH:0];

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StWrLo,
    StWrHi,
    StDone,
    StErr
  } state_e;

  state_e                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CountWidth-1:0]      remaining_q, remaining_d;
  logic [INST_DATA_WIDTH-1:0] word_q, word_d;
  logic                       exc_q, exc_d;
  logic                       busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      exc_q       <= exc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    exc_d       = exc_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ptr_d       = bus.base_addr;
          remaining_d = bus.word_count;
          exc_d       = 1'b0;
          if (bus.word_count == '0) begin
            state_d = StDone;
          end else if (bus.base_addr[0]) begin
            state_d = StErr;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus.in_valid) begin
          word_d = bus.in_data;
          // Range check happens before any byte of this word is written.
          if ({1'b0, ptr_q} > LastWordAddr) begin
            state_d = StErr;
          end else begin
            state_d = StWrLo;
          end
        end
      end
      StWrLo: begin
        state_d = StWrHi;
      end
      StWrHi: begin
        ptr_d       = ptr_q + INST_ADDR_WIDTH'(2);
        remaining_d = remaining_q - CountWidth'(1);
        if (remaining_q == CountWidth'(1)) begin
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        exc_d   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode; address and data are forced to zero outside the write states.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;

    unique case (state_q)
      StWait: begin
        bus.in_ready = 1'b1;
      end
      StWrLo: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = ptr_q;
        bus.mem_wdata = word_q[7:0];
      end
      StWrHi: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = ptr_q + INST_ADDR_WIDTH'(1);
        bus.mem_wdata = word_q[INST_DATA_WIDTH-1:8];
      end
      StDone: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase

    busy         = (state_q != StIdle);
    bus.busy     = busy;
    bus.cpu_hold = busy;
    bus.exc      = exc_q;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: a table of load vectors with hand-computed
// byte writes, status and cycle counts, plus scripted sequences for start-while-busy
// and reset in the middle of a word.
module tb_inst_mem_loader;

  logic clk;
  logic rst;

  inst_mem_loader_if #(.INST_ADDR_WIDTH(16), .INST_DATA_WIDTH(16)) bus ();

  inst_mem_loader #(
    .INST_ADDR_WIDTH(16),
    .INST_DATA_WIDTH(16),
    .INST_MEM_SIZE  (4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      base;
    logic [15:0]      count;
    logic [15:0]      w0;
    logic [15:0]      w1;
    int               gap;
    int               n_wr;
    logic [3:0][15:0] wa;
    logic [3:0][7:0]  wd;
    int               exp_done;
    logic             exp_exc;
    int               exp_xfer;
    int               exp_ready;
    int               exp_cyc;
  } vec_t;

  vec_t vecs[7];

  int n_checks;
  int n_fail;
  int gap_bad;

  // Passive monitor, sampled on the falling edge.
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          done_cnt  = 0;
  int          ready_cyc = 0;
  int          hold_bad  = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.in_ready === 1'b1) ready_cyc++;
    if (bus.cpu_hold !== bus.busy) hold_bad++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one load and act as the word source until the loader returns to idle.
  // A nonzero gap holds in_valid low for that many waiting cycles between words.
  task automatic run_load(input logic [15:0] base, input logic [15:0] cnt,
                          input logic [15:0] w0, input logic [15:0] w1, input int gap,
                          output int xfers, output int cyc, output bit tmo);
    int gapc;
    bit in_gap;
    xfers  = 0;
    cyc    = 0;
    gapc   = 0;
    in_gap = 1'b0;
    tmo    = 1'b1;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = cnt;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < 300) begin
      if (!bus.busy) begin
        tmo = 1'b0;
        break;
      end
      if (bus.in_ready) begin
        if (gapc > 0) begin
          bus.in_valid = 1'b0;
          gapc--;
          in_gap = 1'b1;
          if (bus.mem_we) gap_bad++;
        end else begin
          in_gap = 1'b0;
          if (xfers < 2) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (xfers == 0) ? w0 : w1;
            xfers++;
            if (xfers < int'(cnt)) gapc = gap;
          end else begin
            bus.in_valid = 1'b0;
          end
        end
      end else begin
        // Leaving the wait state while the source is idle is a handshake error.
        if (in_gap) gap_bad++;
        in_gap       = 1'b0;
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit tmo);
    int c;
    c   = 0;
    tmo = 1'b1;
    while (c < budget) begin
      if (!bus.busy) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_ready(input int budget);
    int c;
    c = 0;
    while (!bus.in_ready && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  int s_wr, s_done, s_ready, xf, cy;
  bit tmo;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    gap_bad        = 0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;

    //            base     count  w0       w1       gap nwr  addrs (entry 0 rightmost)
    vecs[0] = '{16'h0010, 16'd2, 16'hBEEF, 16'h1234, 0, 4,
                {16'h0013, 16'h0012, 16'h0011, 16'h0010}, {8'h12, 8'h34, 8'hBE, 8'hEF},
                1, 1'b0, 2, 2, 7};
    vecs[1] = '{16'h0010, 16'd2, 16'hBEEF, 16'h1234, 5, 4,
                {16'h0013, 16'h0012, 16'h0011, 16'h0010}, {8'h12, 8'h34, 8'hBE, 8'hEF},
                1, 1'b0, 2, 7, 12};
    vecs[2] = '{16'h0FFE, 16'd2, 16'hA1B2, 16'hC3D4, 0, 2,
                {16'h0000, 16'h0000, 16'h0FFF, 16'h0FFE}, {8'h00, 8'h00, 8'hA1, 8'hB2},
                0, 1'b1, 2, 2, 5};
    vecs[3] = '{16'h0003, 16'd2, 16'h1111, 16'h2222, 0, 0,
                {16'h0, 16'h0, 16'h0, 16'h0}, {8'h0, 8'h0, 8'h0, 8'h0},
                0, 1'b1, 0, 0, 1};
    vecs[4] = '{16'h0020, 16'd0, 16'h3333, 16'h4444, 0, 0,
                {16'h0, 16'h0, 16'h0, 16'h0}, {8'h0, 8'h0, 8'h0, 8'h0},
                1, 1'b0, 0, 0, 1};
    vecs[5] = '{16'h1000, 16'd1, 16'h5555, 16'h6666, 0, 0,
                {16'h0, 16'h0, 16'h0, 16'h0}, {8'h0, 8'h0, 8'h0, 8'h0},
                0, 1'b1, 1, 1, 2};
    vecs[6] = '{16'h0040, 16'd1, 16'h5A6B, 16'h0000, 0, 2,
                {16'h0000, 16'h0000, 16'h0041, 16'h0040}, {8'h00, 8'h00, 8'h5A, 8'h6B},
                1, 1'b0, 1, 1, 4};

    repeat (3) @(negedge clk);
    check("rst_busy",      32'(bus.busy), 32'd0);
    check("rst_cpu_hold",  32'(bus.cpu_hold), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_done",      32'(bus.done), 32'd0);
    check("rst_exc",       32'(bus.exc), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      s_wr    = wr_addr.size();
      s_done  = done_cnt;
      s_ready = ready_cyc;
      gap_bad = 0;
      run_load(vecs[i].base, vecs[i].count, vecs[i].w0, vecs[i].w1, vecs[i].gap, xf, cy, tmo);
      check($sformatf("v%0d_timeout", i), 32'(tmo), 32'd0);
      check($sformatf("v%0d_nwrites", i), 32'(wr_addr.size() - s_wr), 32'(vecs[i].n_wr));
      for (int k = 0; k < vecs[i].n_wr; k++) begin
        if (s_wr + k < wr_addr.size()) begin
          check($sformatf("v%0d_wr%0d_addr", i, k), 32'(wr_addr[s_wr+k]), 32'(vecs[i].wa[k]));
          check($sformatf("v%0d_wr%0d_data", i, k), 32'(wr_data[s_wr+k]), 32'(vecs[i].wd[k]));
        end
      end
      check($sformatf("v%0d_done", i),    32'(done_cnt - s_done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_exc", i),     32'(bus.exc), 32'(vecs[i].exp_exc));
      check($sformatf("v%0d_xfers", i),   32'(xf), 32'(vecs[i].exp_xfer));
      check($sformatf("v%0d_ready", i),   32'(ready_cyc - s_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_cycles", i),  32'(cy), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_gap_ok", i),  32'(gap_bad), 32'd0);
    end

    // start pulsed while the low byte is being written must not restart the load.
    s_wr   = wr_addr.size();
    s_done = done_cnt;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = 16'h0200;
    bus.word_count = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(20);
    check("seqA_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7788;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("seqA_wrlo_we",   32'(bus.mem_we), 32'd1);
    check("seqA_wrlo_addr", 32'(bus.mem_addr), 32'h0200);
    bus.start      = 1'b1;
    bus.base_addr  = 16'h0400;
    bus.word_count = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(20, tmo);
    check("seqA_timeout", 32'(tmo), 32'd0);
    check("seqA_nwrites", 32'(wr_addr.size() - s_wr), 32'd2);
    if (wr_addr.size() - s_wr >= 2) begin
      check("seqA_wr1_addr", 32'(wr_addr[s_wr+1]), 32'h0201);
      check("seqA_wr1_data", 32'(wr_data[s_wr+1]), 32'h77);
    end
    check("seqA_done", 32'(done_cnt - s_done), 32'd1);
    check("seqA_exc",  32'(bus.exc), 32'd0);

    // Reset between the low and high byte: everything drops at once, high byte never lands.
    s_wr   = wr_addr.size();
    s_done = done_cnt;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.base_addr  = 16'h0300;
    bus.word_count = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(20);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h99AA;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("seqB_wrlo_addr", 32'(bus.mem_addr), 32'h0300);
    #1 rst = 1'b0;
    #1;
    check("seqB_busy",      32'(bus.busy), 32'd0);
    check("seqB_cpu_hold",  32'(bus.cpu_hold), 32'd0);
    check("seqB_in_ready",  32'(bus.in_ready), 32'd0);
    check("seqB_mem_we",    32'(bus.mem_we), 32'd0);
    check("seqB_mem_addr",  32'(bus.mem_addr), 32'd0);
    check("seqB_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("seqB_done",      32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("seqB_idle_busy", 32'(bus.busy), 32'd0);
    check("seqB_nwrites",   32'(wr_addr.size() - s_wr), 32'd1);
    check("seqB_no_done",   32'(done_cnt - s_done), 32'd0);

    s_wr   = wr_addr.size();
    s_done = done_cnt;
    run_load(16'h0300, 16'd1, 16'hCAFE, 16'h0000, 0, xf, cy, tmo);
    check("seqB_reload_timeout", 32'(tmo), 32'd0);
    check("seqB_reload_nwrites", 32'(wr_addr.size() - s_wr), 32'd2);
    if (wr_addr.size() - s_wr >= 2) begin
      check("seqB_reload_wr0_addr", 32'(wr_addr[s_wr]),   32'h0300);
      check("seqB_reload_wr0_data", 32'(wr_data[s_wr]),   32'hFE);
      check("seqB_reload_wr1_addr", 32'(wr_addr[s_wr+1]), 32'h0301);
      check("seqB_reload_wr1_data", 32'(wr_data[s_wr+1]), 32'hCA);
    end
    check("seqB_reload_done", 32'(done_cnt - s_done), 32'd1);
    check("seqB_reload_exc",  32'(bus.exc), 32'd0);

    check("cpu_hold_tracks_busy", 32'(hold_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
